// File: rtl/core_io_pkg.sv
// Shared definitions for the core I/O AXI4-Lite master: UART Lite register map,
// status bit positions, AXI response codes and the I/O sequencer state type.
package core_io_pkg;

    localparam logic [3:0] UART_RX_ADDR   = 4'h0;
    localparam logic [3:0] UART_TX_ADDR   = 4'h4;
    localparam logic [3:0] UART_STAT_ADDR = 4'h8;

    localparam int unsigned STAT_RX_VALID_BIT = 0;
    localparam int unsigned STAT_TX_FULL_BIT  = 3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STAT_AR = 3'd1,
        STAT_R  = 3'd2,
        RX_AR   = 3'd3,
        RX_R    = 3'd4,
        TX_AW_W = 3'd5,
        TX_B    = 3'd6,
        RESP    = 3'd7
    } io_state_e;

    function automatic logic resp_is_error(input logic [1:0] resp);
        return (resp != AXI_RESP_OKAY);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO holding prefetched UART receive bytes (show-ahead read port).
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign full      = (count_r == DEPTH_C);
    assign empty     = (count_r == (AW+1)'(0));
    assign dout      = mem_r[rd_ptr_r];

    // Byte storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge CLK) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/core_uart_io.sv
// AXI4-Lite master executing the core's in/out byte requests against a UART Lite.
// Optional receive prefetch FIFO enabled by defining UART_RX_PREFETCH_EN.
module core_uart_io
    import core_io_pkg::*;
#(
    parameter int unsigned RX_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ_VALID,
    input  logic        REQ_WRITE,
    input  logic [7:0]  REQ_WDATA,
    output logic        REQ_READY,
    output logic        RESP_VALID,
    output logic [7:0]  RESP_RDATA,
    output logic        ERR,
    output logic [3:0]  ARADDR,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic [1:0]  RRESP,
    input  logic        RVALID,
    output logic        RREADY,
    output logic [3:0]  AWADDR,
    output logic        AWVALID,
    input  logic        AWREADY,
    output logic [31:0] WDATA,
    output logic [3:0]  WSTRB,
    output logic        WVALID,
    input  logic        WREADY,
    input  logic [1:0]  BRESP,
    input  logic        BVALID,
    output logic        BREADY
);

    io_state_e  state_r;
    logic       wr_r;
    logic [7:0] wdata_r;
    logic       aw_done_r;
    logic       w_done_r;
    logic       aw_hs_s;
    logic       w_hs_s;
    logic       unused_s;

    assign aw_hs_s  = AWVALID && AWREADY;
    assign w_hs_s   = WVALID && WREADY;
    assign unused_s = ^{RDATA[31:8], RX_DEPTH[0]};

`ifdef UART_RX_PREFETCH_EN
    logic       pf_r;
    logic       fifo_push_s;
    logic       fifo_pop_s;
    logic [7:0] fifo_dout_s;
    logic       fifo_full_s;
    logic       fifo_empty_s;

    assign fifo_push_s = (state_r == RX_R) && pf_r && RVALID && RREADY;
    assign fifo_pop_s  = (state_r == IDLE) && REQ_VALID && !REQ_WRITE && !fifo_empty_s;

    uart_rx_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (fifo_push_s),
        .din   (RDATA[7:0]),
        .pop   (fifo_pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );
`endif

    // Request sequencer: every AXI and core-facing output is a register of this block.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r    <= IDLE;
            wr_r       <= 1'b0;
            wdata_r    <= 8'h00;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            REQ_READY  <= 1'b1;
            RESP_VALID <= 1'b0;
            RESP_RDATA <= 8'h00;
            ERR        <= 1'b0;
            ARADDR     <= 4'h0;
            ARVALID    <= 1'b0;
            RREADY     <= 1'b0;
            AWADDR     <= 4'h0;
            AWVALID    <= 1'b0;
            WDATA      <= 32'h0000_0000;
            WSTRB      <= 4'b0000;
            WVALID     <= 1'b0;
            BREADY     <= 1'b0;
`ifdef UART_RX_PREFETCH_EN
            pf_r       <= 1'b0;
`endif
        end else begin
            RESP_VALID <= 1'b0;
            // Error responses are recorded but never abort the transfer.
            if ((RVALID && RREADY && resp_is_error(RRESP)) ||
                (BVALID && BREADY && resp_is_error(BRESP))) begin
                ERR <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (REQ_VALID) begin
                        REQ_READY  <= 1'b0;
                        wr_r       <= REQ_WRITE;
                        wdata_r    <= REQ_WDATA;
                        RESP_RDATA <= 8'h00;
`ifdef UART_RX_PREFETCH_EN
                        pf_r       <= 1'b0;
                        if (!REQ_WRITE && !fifo_empty_s) begin
                            RESP_RDATA <= fifo_dout_s;
                            RESP_VALID <= 1'b1;
                            state_r    <= RESP;
                        end else begin
                            ARADDR  <= UART_STAT_ADDR;
                            ARVALID <= 1'b1;
                            state_r <= STAT_AR;
                        end
`else
                        ARADDR  <= UART_STAT_ADDR;
                        ARVALID <= 1'b1;
                        state_r <= STAT_AR;
`endif
                    end else begin
`ifdef UART_RX_PREFETCH_EN
                        if (!fifo_full_s) begin
                            REQ_READY <= 1'b0;
                            pf_r      <= 1'b1;
                            wr_r      <= 1'b0;
                            ARADDR    <= UART_STAT_ADDR;
                            ARVALID   <= 1'b1;
                            state_r   <= STAT_AR;
                        end
`endif
                    end
                end

                STAT_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state_r <= STAT_R;
                    end
                end

                STAT_R: begin
                    if (RVALID) begin
                        RREADY <= 1'b0;
                        if (wr_r) begin
                            if (RDATA[STAT_TX_FULL_BIT]) begin
                                ARADDR  <= UART_STAT_ADDR;
                                ARVALID <= 1'b1;
                                state_r <= STAT_AR;
                            end else begin
                                AWADDR    <= UART_TX_ADDR;
                                AWVALID   <= 1'b1;
                                WDATA     <= {24'h00_0000, wdata_r};
                                WSTRB     <= 4'b0001;
                                WVALID    <= 1'b1;
                                aw_done_r <= 1'b0;
                                w_done_r  <= 1'b0;
                                state_r   <= TX_AW_W;
                            end
                        end else if (RDATA[STAT_RX_VALID_BIT]) begin
                            ARADDR  <= UART_RX_ADDR;
                            ARVALID <= 1'b1;
                            state_r <= RX_AR;
                        end else begin
`ifdef UART_RX_PREFETCH_EN
                            // An empty prefetch poll yields back to IDLE so requests get a look-in.
                            if (pf_r) begin
                                REQ_READY <= 1'b1;
                                state_r   <= IDLE;
                            end else begin
                                ARADDR  <= UART_STAT_ADDR;
                                ARVALID <= 1'b1;
                                state_r <= STAT_AR;
                            end
`else
                            ARADDR  <= UART_STAT_ADDR;
                            ARVALID <= 1'b1;
                            state_r <= STAT_AR;
`endif
                        end
                    end
                end

                RX_AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state_r <= RX_R;
                    end
                end

                RX_R: begin
                    if (RVALID) begin
                        RREADY <= 1'b0;
`ifdef UART_RX_PREFETCH_EN
                        if (pf_r) begin
                            REQ_READY <= 1'b1;
                            state_r   <= IDLE;
                        end else begin
                            RESP_RDATA <= RDATA[7:0];
                            RESP_VALID <= 1'b1;
                            state_r    <= RESP;
                        end
`else
                        RESP_RDATA <= RDATA[7:0];
                        RESP_VALID <= 1'b1;
                        state_r    <= RESP;
`endif
                    end
                end

                TX_AW_W: begin
                    if (aw_hs_s) begin
                        AWVALID   <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        WVALID   <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                        BREADY  <= 1'b1;
                        state_r <= TX_B;
                    end
                end

                TX_B: begin
                    if (BVALID) begin
                        BREADY     <= 1'b0;
                        RESP_VALID <= 1'b1;
                        state_r    <= RESP;
                    end
                end

                RESP: begin
                    REQ_READY <= 1'b1;
                    state_r   <= IDLE;
                end

                default: begin
                    ARVALID   <= 1'b0;
                    RREADY    <= 1'b0;
                    AWVALID   <= 1'b0;
                    WVALID    <= 1'b0;
                    BREADY    <= 1'b0;
                    REQ_READY <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_uart_io.sv
// Self-checking bench for core_uart_io: randomized requests against a behavioural
// UART Lite slave; expectations come from queue-based register-map semantics.
module tb_core_uart_io;
    import core_io_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ_VALID, REQ_WRITE;
    logic [7:0]  REQ_WDATA;
    logic        REQ_READY, RESP_VALID, ERR;
    logic [7:0]  RESP_RDATA;
    logic [3:0]  ARADDR, AWADDR;
    logic        ARVALID, ARREADY, RREADY, RVALID;
    logic [31:0] RDATA, WDATA;
    logic [1:0]  RRESP, BRESP;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic [3:0]  WSTRB;

    core_uart_io #(.RX_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_WDATA(REQ_WDATA),
        .REQ_READY(REQ_READY), .RESP_VALID(RESP_VALID), .RESP_RDATA(RESP_RDATA), .ERR(ERR),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave model state: STAT answers come from stat_q, otherwise bit0 reflects rx_q occupancy.
    logic [7:0]  stat_q[$];
    logic [7:0]  rx_q[$];
    logic [31:0] tx_data_q[$];
    logic [3:0]  tx_strb_q[$];
    logic [3:0]  tx_addr_q[$];
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    bit          hold_rx = 1'b0;
    int ar_max = 0, r_max = 0, aw_max = 0, w_max = 0, b_max = 0;
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    bit ar_hs_pend, r_pend, r_hs_pend, aw_hs_pend, w_hs_pend, b_hs_pend, aw_got, w_got;
    bit ar_watch, aw_watch, w_watch;
    logic [3:0] r_addr;
    int stat_cnt = 0, rx_cnt = 0, ar_cnt = 0, viol = 0, neg_t = 0, aw_hs_t = 0, w_hs_t = 0;

    task automatic slave_reset();
        ARREADY = 1'b0; RVALID = 1'b0; RDATA = 32'h0; RRESP = 2'b00;
        AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
        ar_hs_pend = 1'b0; r_pend = 1'b0; r_hs_pend = 1'b0; aw_hs_pend = 1'b0;
        w_hs_pend = 1'b0; b_hs_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0;
        ar_watch = 1'b0; aw_watch = 1'b0; w_watch = 1'b0;
    endtask

    task automatic slave_step();
        logic [7:0] b;
        neg_t++;
        if (!RST_N) begin
            slave_reset();
            return;
        end
        if ((ar_watch && !ARVALID) || (aw_watch && !AWVALID) || (w_watch && !WVALID)) viol++;
        if (ar_hs_pend) begin
            ARREADY = 1'b0; ar_hs_pend = 1'b0; r_pend = 1'b1;
            r_wait = $urandom_range(r_max, 0); ar_wait = $urandom_range(ar_max, 0);
        end
        if (r_hs_pend) begin RVALID = 1'b0; r_hs_pend = 1'b0; end
        if (aw_hs_pend) begin AWREADY = 1'b0; aw_hs_pend = 1'b0; aw_got = 1'b1; aw_wait = $urandom_range(aw_max, 0); end
        if (w_hs_pend) begin WREADY = 1'b0; w_hs_pend = 1'b0; w_got = 1'b1; w_wait = $urandom_range(w_max, 0); end
        if (b_hs_pend) begin
            BVALID = 1'b0; b_hs_pend = 1'b0; aw_got = 1'b0; w_got = 1'b0; b_wait = $urandom_range(b_max, 0);
        end
        if (ARVALID && !r_pend && !RVALID && !ar_hs_pend) begin
            if (ar_wait > 0) ar_wait--;
            else begin ARREADY = 1'b1; ar_hs_pend = 1'b1; r_addr = ARADDR; ar_cnt++; end
        end
        if (r_pend) begin
            if (r_wait > 0) r_wait--;
            else if (!(hold_rx && r_addr == UART_RX_ADDR)) begin
                if (r_addr == UART_STAT_ADDR) begin
                    stat_cnt++;
                    b = (stat_q.size() != 0) ? stat_q.pop_front() : ((rx_q.size() != 0) ? 8'h01 : 8'h00);
                end else begin
                    rx_cnt++;
                    b = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                end
                RVALID = 1'b1; RRESP = rresp_cfg; RDATA = {24'($urandom), b}; r_pend = 1'b0;
            end
        end
        if (RVALID && RREADY && !r_hs_pend) r_hs_pend = 1'b1;
        if (AWVALID && !aw_got && !aw_hs_pend) begin
            if (aw_wait > 0) aw_wait--;
            else begin AWREADY = 1'b1; aw_hs_pend = 1'b1; tx_addr_q.push_back(AWADDR); aw_hs_t = neg_t; end
        end
        if (WVALID && !w_got && !w_hs_pend) begin
            if (w_wait > 0) w_wait--;
            else begin
                WREADY = 1'b1; w_hs_pend = 1'b1; w_hs_t = neg_t;
                tx_data_q.push_back(WDATA); tx_strb_q.push_back(WSTRB);
            end
        end
        if (aw_got && w_got && !BVALID && !b_hs_pend) begin
            if (b_wait > 0) b_wait--;
            else begin BVALID = 1'b1; BRESP = bresp_cfg; end
        end
        if (BVALID && BREADY && !b_hs_pend) b_hs_pend = 1'b1;
        ar_watch = ARVALID && !ar_hs_pend;
        aw_watch = AWVALID && !aw_hs_pend;
        w_watch  = WVALID && !w_hs_pend;
    endtask

    initial begin
        slave_reset();
        forever begin
            @(negedge CLK);
            slave_step();
        end
    end

    // One request: lat counts cycles from the accept edge to the RESP_VALID cycle.
    task automatic do_req(input bit wr, input logic [7:0] wd, output logic [7:0] rd,
                          output int lat, output int extra_pulse, output int ar_delta);
        int guard = 0;
        int ar0;
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_WRITE = wr; REQ_WDATA = wd;
        while (!REQ_READY && guard < 500) begin @(negedge CLK); guard++; end
        ar0 = ar_cnt;
        @(negedge CLK);
        REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_WDATA = 8'h00;
        lat = 1;
        while (!RESP_VALID && lat < 500) begin @(negedge CLK); lat++; end
        chk("resp_seen", {31'h0, RESP_VALID}, 32'h1);
        rd = RESP_RDATA;
        ar_delta = ar_cnt - ar0;
        @(negedge CLK);
        extra_pulse = RESP_VALID;
    endtask

    task automatic pulse_reset();
        @(negedge CLK); RST_N = 1'b0; REQ_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, b, wd;
        int lat, xp, ard, s0, r0, k;
        bit wr;
        RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_WDATA = 8'h00;
        repeat (3) @(negedge CLK);
        chk("rst_req_ready", {31'h0, REQ_READY}, 32'h1);
        chk("rst_err", {31'h0, ERR}, 32'h0);
        chk("rst_valids", {26'h0, ARVALID, RREADY, AWVALID, WVALID, BREADY, RESP_VALID}, 32'h0);
        chk("rst_buses", {ARADDR, AWADDR, WSTRB, RESP_RDATA, 12'h0}, 32'h0);
        chk("rst_wdata", WDATA, 32'h0);
        RST_N = 1'b1;

`ifndef UART_RX_PREFETCH_EN
        // Zero-wait read with data ready on the first poll.
        stat_q.push_back(8'h01); rx_q.push_back(8'h41);
        s0 = stat_cnt; r0 = rx_cnt;
        do_req(1'b0, 8'h00, rd, lat, xp, ard);
        chk("rd0_data", rd, 8'h41);
        chk("rd0_latency", lat, 5);
        chk("rd0_pulse_once", xp, 0);
        chk("rd0_err", ERR, 0);
        chk("rd0_polls", {stat_cnt - s0, rx_cnt - r0}, {32'd1, 32'd1});

        // Two empty polls before data.
        stat_q.push_back(8'h00); stat_q.push_back(8'h00); stat_q.push_back(8'h01); rx_q.push_back(8'h0A);
        s0 = stat_cnt; r0 = rx_cnt;
        do_req(1'b0, 8'h00, rd, lat, xp, ard);
        chk("rd1_data", rd, 8'h0A);
        chk("rd1_stat_reads", stat_cnt - s0, 3);
        chk("rd1_rx_reads", rx_cnt - r0, 1);

        // TX full once, then AW held off for three cycles while W is taken at once.
        stat_q.push_back(8'h08); stat_q.push_back(8'h00); aw_wait = 3;
        do_req(1'b1, 8'h5A, rd, lat, xp, ard);
        chk("wr0_w_before_aw", aw_hs_t - w_hs_t, 3);
        chk("wr0_wdata", tx_data_q.pop_front(), 32'h0000_005A);
        chk("wr0_wstrb", tx_strb_q.pop_front(), 4'b0001);
        chk("wr0_awaddr", tx_addr_q.pop_front(), UART_TX_ADDR);
        chk("wr0_pulse_once", xp, 0);
        chk("wr0_rdata_zero", rd, 8'h00);

        ar_max = 2; r_max = 2; aw_max = 3; w_max = 3; b_max = 2;
`endif

        // Randomized mix of reads and writes against the register-map model.
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom);
`ifdef UART_RX_PREFETCH_EN
            k = 0;
`else
            k = $urandom_range(2, 0);
            for (int j = 0; j < k; j++)
                stat_q.push_back(wr ? (8'($urandom) | 8'h08) : (8'($urandom) & 8'hFE));
            stat_q.push_back(wr ? (8'($urandom) & 8'hF7) : (8'($urandom) | 8'h01));
`endif
            b = 8'($urandom); wd = 8'($urandom);
            if (!wr) rx_q.push_back(b);
            s0 = stat_cnt;
            do_req(wr, wd, rd, lat, xp, ard);
            if (wr) begin
                chk("rnd_wdata", (tx_data_q.size() != 0) ? tx_data_q.pop_front() : 32'hDEAD_BEEF, {24'h0, wd});
                chk("rnd_wstrb", (tx_strb_q.size() != 0) ? tx_strb_q.pop_front() : 4'hF, 4'b0001);
                chk("rnd_awaddr", (tx_addr_q.size() != 0) ? tx_addr_q.pop_front() : 4'hF, UART_TX_ADDR);
                chk("rnd_wr_rdata", rd, 8'h00);
            end else begin
                chk("rnd_rdata", rd, b);
            end
`ifndef UART_RX_PREFETCH_EN
            chk("rnd_stat_reads", stat_cnt - s0, k + 1);
            chk("rnd_latency_min", (lat >= 5 + 2 * k) ? 1 : 0, 1);
`endif
            chk("rnd_pulse_once", xp, 0);
        end
        chk("rnd_err_clean", ERR, 0);
        ar_max = 0; r_max = 0; aw_max = 0; w_max = 0; b_max = 0;

        // SLVERR on B: transfer completes, ERR sticks across later requests until reset.
        repeat (4) @(negedge CLK);
        bresp_cfg = 2'b10;
        do_req(1'b1, 8'h77, rd, lat, xp, ard);
        bresp_cfg = 2'b00;
        chk("berr_wdata", (tx_data_q.size() != 0) ? tx_data_q.pop_front() : 32'hDEAD_BEEF, 32'h0000_0077);
        chk("berr_pulse_once", xp, 0);
        chk("berr_err_set", ERR, 1);
        void'(tx_strb_q.pop_front()); void'(tx_addr_q.pop_front());
        rx_q.push_back(8'h55);
        do_req(1'b0, 8'h00, rd, lat, xp, ard);
        chk("berr_next_read", rd, 8'h55);
        chk("berr_err_sticky", ERR, 1);
        pulse_reset();
        chk("berr_err_cleared", ERR, 0);

        // Reset while stuck in the RX data phase.
        hold_rx = 1'b1; rx_q.push_back(8'h11);
        @(negedge CLK); REQ_VALID = 1'b1; REQ_WRITE = 1'b0;
        k = 0;
        while (!(RREADY && ARADDR == UART_RX_ADDR) && k < 200) begin @(negedge CLK); k++; end
        chk("mid_rst_reached_rx_r", (k < 200) ? 1 : 0, 1);
        RST_N = 1'b0; REQ_VALID = 1'b0;
        @(negedge CLK);
        chk("mid_rst_valids", {26'h0, ARVALID, RREADY, AWVALID, WVALID, BREADY, RESP_VALID}, 32'h0);
        chk("mid_rst_req_ready", REQ_READY, 1);
        @(negedge CLK);
        RST_N = 1'b1; hold_rx = 1'b0;
        do_req(1'b0, 8'h00, rd, lat, xp, ard);
        chk("post_rst_read", rd, 8'h11);

`ifdef UART_RX_PREFETCH_EN
        // Bytes pulled in while idle are served one cycle after accept without AXI traffic.
        rx_q.push_back(8'h31); rx_q.push_back(8'h32);
        repeat (40) @(negedge CLK);
        do_req(1'b0, 8'h00, rd, lat, xp, ard);
        chk("pf0_data", rd, 8'h31);
        chk("pf0_latency", lat, 1);
        chk("pf0_no_ar", ard, 0);
        do_req(1'b0, 8'h00, rd, lat, xp, ard);
        chk("pf1_data", rd, 8'h32);
        chk("pf1_latency", lat, 1);
        chk("pf1_no_ar", ard, 0);
`endif

        chk("valid_never_dropped_early", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_uart_io.md
# core_uart_io

Stand-alone AXI4-Lite master that executes the core's `in`/`out` byte requests against the UART Lite slave. It lives directly downstream of the core's MEMORY stage and replaces the inline I/O state machine there. The core issues one request and stalls until a single-cycle response pulse. For reads, that pulse carries the received byte. Optionally, a small receive prefetch buffer hides UART polling latency.

## Interface
Parameters:
- RX_DEPTH, 4: prefetch FIFO depth, power of two, ≥2 (used only with UART_RX_PREFETCH_EN).

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, synchronous, active-low
- REQ_VALID  in  1  core request valid; held until accepted
- REQ_WRITE  in  1  1 = `out`, 0 = `in`
- REQ_WDATA  in  8  byte to transmit
- REQ_READY  out  1  block idle and able to accept
- RESP_VALID  out  1  one-cycle completion pulse
- RESP_RDATA  out  8  received byte; valid with RESP_VALID on reads, 0 on writes
- ERR  out  1  sticky; set on any RRESP/BRESP ≠ 0
- ARADDR  out  4, ARVALID  out  1, ARREADY  in  1
- RDATA  in  32, RRESP  in  2, RVALID  in  1, RREADY  out  1
- AWADDR  out  4, AWVALID  out  1, AWREADY  in  1
- WDATA  out  32, WSTRB  out  4, WVALID  out  1, WREADY  in  1
- BRESP  in  2, BVALID  in  1, BREADY  out  1

## Operation
- UART register map:
  - 0x0 RX FIFO
  - 0x4 TX FIFO
  - 0x8 STAT: bit0 = RX data valid, bit3 = TX full.
- Request accept: a request is accepted on REQ_VALID & REQ_READY. REQ_WRITE and REQ_WDATA are captured at accept.
- FSM states: IDLE, STAT_AR, STAT_R, RX_AR, RX_R, TX_AW_W, TX_B, RESP.
- Read path:
  - IDLE → STAT_AR (ARADDR=0x8) → STAT_R.
  - In STAT_R: if bit0 = 1, go to RX_AR (ARADDR=0x0) → RX_R → RESP. Otherwise return to STAT_AR.
- Write path:
  - IDLE → STAT_AR → STAT_R.
  - In STAT_R: if bit3 = 1, return to STAT_AR. Otherwise go to TX_AW_W → TX_B → RESP.
  - TX_AW_W drives AWADDR=0x4, WDATA={24'b0, byte}, WSTRB=4'b0001.
- RESP: asserts RESP_VALID for one cycle, then returns to IDLE.
- AR handshake: ARVALID is high for the whole of each *_AR state and drops on the cycle after ARVALID & ARREADY.
- R handshake: RREADY is high in each *_R state. RDATA is captured on RVALID & RREADY.
- AW/W handshake: AWVALID and WVALID rise together on entry to TX_AW_W. Each one drops independently after its own handshake. The FSM leaves TX_AW_W only once both have completed, whether they complete in the same cycle or in different cycles.
- B handshake: BREADY is high in TX_B. The FSM exits on BVALID.
- Errors: a nonzero RRESP or BRESP sets ERR. The transaction still completes normally, and on a read the returned byte is RDATA[7:0] regardless.
- VALID signals never drop before their handshake completes.
- Reset mid-operation:
  - FSM goes to IDLE on the reset edge and every VALID/READY output drops.
  - The outstanding AXI transaction is abandoned; the UART slave shares RST_N.

## Timing
- Reset values: REQ_READY=1 and ERR=0. Every other output resets to 0, including all VALID/READY signals, all address and data buses, and WSTRB.
- REQ_READY is high only in IDLE.
- Read latency with zero-wait slave:
  - request accepted at cycle 0
  - STAT ARVALID in cycle 1
  - RREADY in cycle 2
  - RX ARVALID in cycle 3
  - RREADY in cycle 4
  - RESP_VALID in cycle 5
- Write latency with zero-wait slave:
  - STAT read in cycles 1–2
  - AW/W in cycle 3
  - B in cycle 4
  - RESP_VALID in cycle 5
- Each additional status poll adds at least 2 cycles.
- RESP_RDATA is held until the next accepted request.

## Configuration
- Macro: `UART_RX_PREFETCH_EN`.
- Defined:
  - While IDLE with no pending request, the FSM polls STAT and pulls bytes into an RX_DEPTH FIFO until it is full.
  - A read request while the FIFO is non-empty pops the FIFO: RESP_VALID follows accept by 1 cycle, with no AXI traffic.
  - A request arriving during a prefetch transaction is accepted only after that transaction finishes (REQ_READY=0 throughout).
  - When FIFO full, polling stops.
  - Reset empties the FIFO.
- Undefined: no FIFO or prefetch logic exists, and the FSM follows only the behaviour described in Operation.

## Structure
- Shared package `core_io_pkg` holds:
  - register offsets UART_RX_ADDR, UART_TX_ADDR, UART_STAT_ADDR
  - status bit indices STAT_RX_VALID_BIT=0 and STAT_TX_FULL_BIT=3
  - the FSM state typedef
  - the AXI OKAY response constant
- Sub-module `uart_rx_fifo`: a synchronous FIFO with push/pop/full/empty, instantiated only under UART_RX_PREFETCH_EN.

## Test plan
- Zero-wait slave with STAT=0x01 and RX=0x41; read request → RESP_VALID in cycle 5 with RESP_RDATA=0x41 and ERR=0.
- STAT reads 0x00 twice, then 0x01 with RX=0x0A → exactly 3 STAT reads, 1 RX read, and RESP_RDATA=0x0A.
- Write 0x5A, slave with STAT=0x08 once then 0x00, AWREADY delayed 3 cycles, WREADY immediate → WVALID drops first, AW completes later, WDATA=0x0000005A, WSTRB=0001, a single RESP_VALID pulse, and no early VALID drop.
- BRESP=2'b10 on a write → write completes, RESP_VALID pulses, and ERR stays 1 through following requests until reset.
- RST_N asserted while the block sits in RX_R with RVALID withheld → next cycle all VALID/READY outputs are 0 and REQ_READY=1; a fresh read afterwards completes normally.
- With UART_RX_PREFETCH_EN, idle period, slave providing 0x31, 0x32 → two read requests each return within 1 cycle of accept (0x31, then 0x32) with no AR traffic during those reads.
